mc_cpu: RTL and testbench

Multi-cycle, parametrised MIPS-subset core that replaces the single-cycle R-type datapath. It adds I-type arithmetic/logic, optional conditional branches, a fetch handshake to a variable-latency instruction memory, and overflow-suppressed writeback. It sits between the instruction memory and the board debug outputs. It retires one instruction every 4 or more cycles through a fetch/wait/execute/writeback FSM.

---
 rtl/mc_cpu_pkg.sv | 24 ++
 rtl/mc_regfile.sv | 32 +++
 rtl/mc_cpu.sv | 197 +++++++++++++++++++
 tb/tb_mc_cpu.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_cpu_pkg.sv
// Shared opcode/funct encodings, ALU operation and FSM state types for mc_cpu.
package mc_cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {ADD, SUB, AND, OR, XOR, NOR, SLT, SLL} alu_op_e;

  typedef enum logic [1:0] {FETCH, WAIT, EXEC, WB} state_e;

endpackage

// File: rtl/mc_regfile.sv
// Register file: two combinational read ports, one write port, r0 hardwired to zero.
module mc_regfile
  import mc_cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [$clog2(REG_N)-1:0] ra_i,
  input  logic [$clog2(REG_N)-1:0] rb_i,
  output logic [DATA_W-1:0]        rdata_a_o,
  output logic [DATA_W-1:0]        rdata_b_o,
  input  logic                     we_i,
  input  logic [$clog2(REG_N)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i
);

  logic [DATA_W-1:0] regs_q [REG_N];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (ra_i == '0) ? '0 : regs_q[ra_i];
  assign rdata_b_o = (rb_i == '0) ? '0 : regs_q[rb_i];

endmodule

// File: rtl/mc_cpu.sv
// Multi-cycle MIPS-subset core (FETCH/WAIT/EXEC/WB). Define MC_CPU_BRANCH_EN to
// enable beq/bne; otherwise those opcodes are treated as illegal.
module mc_cpu
  import mc_cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int REG_N  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic [DATA_W-1:0] result,
  output logic              alu_of,
  output logic              alu_zf,
  output logic              illegal
);

  localparam int IDX_W = $clog2(REG_N);

  function automatic logic [DATA_W-1:0] ext_imm(input logic [15:0] imm, input logic sgn);
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W; i++) v[i] = (i < 16) ? imm[i[3:0]] : (sgn & imm[15]);
    return v;
  endfunction

  function automatic logic [ADDR_W-1:0] br_off(input logic [15:0] imm);
    logic [31:0] w;
    w = {{14{imm[15]}}, imm, 2'b00};
    return w[ADDR_W-1:0];
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       ir_q;
  logic [DATA_W-1:0] result_q;
  logic              of_q, zf_q, ill_q, wen_q, taken_q;
  logic [IDX_W-1:0]  wdst_q;

  logic [5:0]        op, fn;
  logic [4:0]        shamt;
  logic [15:0]       imm;
  logic [IDX_W-1:0]  rs, rt, rd, dst;
  logic [DATA_W-1:0] rs_val, rt_val;
  alu_op_e           alu_op;
  logic              use_imm, imm_sgn, wr_en, legal, arith, is_br, br_ne;
  logic signed [DATA_W-1:0] opa, opb, alu_sum, alu_diff;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[21 +: IDX_W];
  assign rt    = ir_q[16 +: IDX_W];
  assign rd    = ir_q[11 +: IDX_W];
  assign shamt = ir_q[10:6];
  assign fn    = ir_q[5:0];
  assign imm   = ir_q[15:0];

  mc_regfile #(.DATA_W(DATA_W), .REG_N(REG_N)) u_rf (
    .CLK      (CLK),
    .RST      (RST),
    .ra_i     (rs),
    .rb_i     (rt),
    .rdata_a_o(rs_val),
    .rdata_b_o(rt_val),
    .we_i     ((state_q == WB) && wen_q),
    .waddr_i  (wdst_q),
    .wdata_i  (result_q)
  );

  always_comb begin
    alu_op  = ADD;
    use_imm = 1'b0;
    imm_sgn = 1'b0;
    wr_en   = 1'b0;
    legal   = 1'b1;
    arith   = 1'b0;
    is_br   = 1'b0;
    br_ne   = 1'b0;
    dst     = rd;
    case (op)
      OP_RTYPE: begin
        wr_en = 1'b1;
        case (fn)
          FN_ADD:  begin alu_op = ADD; arith = 1'b1; end
          FN_SUB:  begin alu_op = SUB; arith = 1'b1; end
          FN_AND:  alu_op = AND;
          FN_OR:   alu_op = OR;
          FN_XOR:  alu_op = XOR;
          FN_NOR:  alu_op = NOR;
          FN_SLT:  alu_op = SLT;
          FN_SLL:  alu_op = SLL;
          default: begin legal = 1'b0; wr_en = 1'b0; end
        endcase
      end
      OP_ADDI: begin
        alu_op = ADD; use_imm = 1'b1; imm_sgn = 1'b1; arith = 1'b1; wr_en = 1'b1; dst = rt;
      end
      OP_ANDI: begin alu_op = AND; use_imm = 1'b1; wr_en = 1'b1; dst = rt; end
      OP_ORI:  begin alu_op = OR;  use_imm = 1'b1; wr_en = 1'b1; dst = rt; end
`ifdef MC_CPU_BRANCH_EN
      OP_BEQ, OP_BNE: begin alu_op = SUB; is_br = 1'b1; br_ne = op[0]; end
`endif
      default: legal = 1'b0;
    endcase
  end

  // ALU: overflow from sign of operands vs. sign of the DATA_W-bit result
  always_comb begin
    opa      = rs_val;
    opb      = use_imm ? ext_imm(imm, imm_sgn) : rt_val;
    alu_sum  = opa + opb;
    alu_diff = opa - opb;
    alu_res  = '0;
    alu_ovf  = 1'b0;
    case (alu_op)
      ADD: begin
        alu_res = alu_sum;
        alu_ovf = (opa[DATA_W-1] == opb[DATA_W-1]) && (alu_sum[DATA_W-1] != opa[DATA_W-1]);
      end
      SUB: begin
        alu_res = alu_diff;
        alu_ovf = (opa[DATA_W-1] != opb[DATA_W-1]) && (alu_diff[DATA_W-1] != opa[DATA_W-1]);
      end
      AND: alu_res = opa & opb;
      OR:  alu_res = opa | opb;
      XOR: alu_res = opa ^ opb;
      NOR: alu_res = ~(opa | opb);
      SLT: alu_res = DATA_W'(opa < opb);
      SLL: alu_res = (int'(shamt) >= DATA_W) ? '0 : DATA_W'(opb << shamt);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = WAIT;
      WAIT:    if (imem_valid) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (state_q == WAIT && imem_valid) ir_q <= imem_rdata;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= FETCH;
      pc_q     <= '0;
      result_q <= '0;
      of_q     <= 1'b0;
      zf_q     <= 1'b0;
      ill_q    <= 1'b0;
      wen_q    <= 1'b0;
      taken_q  <= 1'b0;
      wdst_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == EXEC) begin
        wdst_q <= dst;
        if (legal) begin
          result_q <= alu_res;
          zf_q     <= (alu_res == '0);
          if (arith) of_q <= alu_ovf;
          wen_q    <= wr_en && !(arith && alu_ovf);
          taken_q  <= is_br && ((alu_res == '0) != br_ne);
        end else begin
          ill_q   <= 1'b1;
          wen_q   <= 1'b0;
          taken_q <= 1'b0;
        end
      end
      if (state_q == WB)
        pc_q <= taken_q ? pc_q + ADDR_W'(4) + br_off(imm) : pc_q + ADDR_W'(4);
    end
  end

  // Request is gated by RST so it stays low while reset is held
  assign imem_req  = (state_q == FETCH) && !RST;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign retire    = (state_q == WB);
  assign result    = result_q;
  assign alu_of    = of_q;
  assign alu_zf    = zf_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_mc_cpu.sv
// Self-checking bench for mc_cpu: directed scenarios plus random instructions
// compared against an instruction-level model of the architectural state.
module tb_mc_cpu;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int REG_N  = 32;
  localparam longint MAXV = 2147483647;
  localparam longint MINV = -MAXV - 1;

  logic              CLK = 1'b0;
  logic              RST;
  logic              imem_req, imem_valid, retire, alu_of, alu_zf, illegal;
  logic [ADDR_W-1:0] imem_addr, pc;
  logic [31:0]       imem_rdata;
  logic [DATA_W-1:0] result;

  int tests, fails;

  logic [31:0] m_reg [32];
  logic [7:0]  m_pc;
  logic [31:0] m_res;
  logic        m_of, m_zf, m_ill;

  mc_cpu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_N(REG_N)) dut (
    .CLK(CLK), .RST(RST), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .pc(pc), .retire(retire),
    .result(result), .alu_of(alu_of), .alu_zf(alu_zf), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_pc = '0; m_res = '0; m_of = 1'b0; m_zf = 1'b0; m_ill = 1'b0;
  endtask

  task automatic model_exec(input logic [31:0] w);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh, dst;
    logic [15:0] imm;
    logic [31:0] a, b, r;
    longint      sa, sb, wide;
    bit          legal, wr, arith, ov, take;
    op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; sh = w[10:6];
    fn = w[5:0]; imm = w[15:0];
    a = m_reg[rs]; b = m_reg[rt];
    sa = longint'($signed(a)); sb = longint'($signed(b));
    legal = 1; wr = 1; arith = 0; ov = 0; take = 0; dst = rd; r = '0; wide = 0;
    if (op == 6'h00) begin
      case (fn)
        6'h20: begin wide = sa + sb; arith = 1; end
        6'h22: begin wide = sa - sb; arith = 1; end
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2A: r = (sa < sb) ? 32'd1 : 32'd0;
        6'h00: r = b << sh;
        default: legal = 0;
      endcase
    end else if (op == 6'h08) begin
      wide = sa + longint'($signed(imm)); arith = 1; dst = rt;
    end else if (op == 6'h0C) begin
      r = a & {16'h0, imm}; dst = rt;
    end else if (op == 6'h0D) begin
      r = a | {16'h0, imm}; dst = rt;
`ifdef MC_CPU_BRANCH_EN
    end else if (op == 6'h04 || op == 6'h05) begin
      wr = 0; r = a - b;
      take = (op == 6'h04) ? (a == b) : (a != b);
`endif
    end else begin
      legal = 0;
    end
    if (arith) begin
      r  = wide[31:0];
      ov = (wide > MAXV) || (wide < MINV);
    end
    if (!legal) m_ill = 1'b1;
    else begin
      m_res = r;
      m_zf  = (r == 0);
      if (arith) m_of = ov;
      if (wr && !ov && dst != 0) m_reg[dst] = r;
    end
    m_pc = take ? 8'(int'(m_pc) + 4 + int'($signed(imm)) * 4) : m_pc + 8'd4;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!imem_req && n < 20) begin @(posedge CLK); #1; n++; end
    ok = imem_req;
    if (!ok) check("req_timeout", 0, 1);
  endtask

  // One instruction: FETCH, delay+1 WAIT cycles, EXEC, WB; retire expected at cycle 4+delay
  task automatic run(input logic [31:0] w, input int delay, input bit spur, input bit junk);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    check("fetch_addr", imem_addr, m_pc);
    check("fetch_pc", pc, m_pc);
    imem_valid = junk; imem_rdata = $urandom;
    for (int i = 0; i < delay; i++) begin
      @(posedge CLK); #1;
      imem_valid = 1'b0; imem_rdata = $urandom;
      check("wait_addr", imem_addr, m_pc);
      check("wait_req", imem_req, 0);
    end
    @(posedge CLK); #1;
    imem_valid = 1'b1; imem_rdata = w;
    @(posedge CLK); #1;
    imem_valid = spur; imem_rdata = $urandom;
    check("exec_retire", retire, 0);
    @(posedge CLK); #1;
    imem_valid = 1'b0;
    check("wb_retire", retire, 1);
    model_exec(w);
    check("result", result, m_res);
    check("alu_of", alu_of, m_of);
    check("alu_zf", alu_zf, m_zf);
    check("illegal", illegal, m_ill);
  endtask

  task automatic do_reset();
    RST = 1'b1; imem_valid = 1'b1; imem_rdata = $urandom;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_req", imem_req, 0);
    check("rst_retire", retire, 0);
    check("rst_result", result, 0);
    check("rst_of", alu_of, 0);
    check("rst_zf", alu_zf, 0);
    check("rst_illegal", illegal, 0);
    check("rst_pc", pc, 0);
    RST = 1'b0;
    #1;
    check("req_after_rst", imem_req, 1);
    model_reset();
  endtask

  task automatic run_abort(input logic [31:0] w);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    imem_valid = 1'b0;
    @(posedge CLK); #1;
    imem_valid = 1'b1; imem_rdata = w;
    @(posedge CLK); #1;
    imem_valid = 1'b0;
    check("abort_exec_retire", retire, 0);
    RST = 1'b1;
    #1;
    check("abort_pc", pc, 0);
    check("abort_req", imem_req, 0);
    @(posedge CLK); #1;
    check("abort_retire", retire, 0);
    check("abort_result", result, 0);
    RST = 1'b0;
    #1;
    check("abort_req_release", imem_req, 1);
    model_reset();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    int k;
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    k = $urandom_range(0, 14);
    case (k)
      0: return rtype(6'h20, rd, rs, rt, 5'd0);
      1: return rtype(6'h22, rd, rs, rt, 5'd0);
      2: return rtype(6'h24, rd, rs, rt, 5'd0);
      3: return rtype(6'h25, rd, rs, rt, 5'd0);
      4: return rtype(6'h26, rd, rs, rt, 5'd0);
      5: return rtype(6'h27, rd, rs, rt, 5'd0);
      6: return rtype(6'h2A, rd, rs, rt, 5'd0);
      7: return rtype(6'h00, rd, rs, rt, 5'($urandom));
      8: return itype(6'h08, rt, rs, imm);
      9: return itype(6'h0C, rt, rs, imm);
      10, 11: return itype(6'h0D, rt, rs, imm);
      12: return itype(($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05, rt, rs,
                      16'($urandom_range(0, 8)) - 16'd4);
      13: return rtype(6'h3F, rd, rs, rt, 5'd0);
      default: return itype(6'h3F, rt, rs, imm);
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0;
    RST = 1'b1; imem_valid = 1'b0; imem_rdata = '0;
    model_reset();

    do_reset();
    run(itype(6'h08, 5'd1, 5'd0, 16'd5), 0, 0, 0);
    check("addi_res5", result, 5);
    run(rtype(6'h20, 5'd2, 5'd1, 5'd1, 5'd0), 0, 0, 1);
    check("add_res10", result, 10);
    run(rtype(6'h22, 5'd3, 5'd2, 5'd2, 5'd0), 0, 0, 0);
    check("sub_zf", alu_zf, 1);

    run(itype(6'h0D, 5'd1, 5'd0, 16'h7FFF), 0, 0, 0);
    run(rtype(6'h00, 5'd1, 5'd0, 5'd1, 5'd16), 0, 0, 0);
    run(itype(6'h0D, 5'd1, 5'd1, 16'hFFFF), 0, 0, 0);
    check("max_pos", result, 32'h7FFF_FFFF);
    run(rtype(6'h20, 5'd4, 5'd1, 5'd1, 5'd0), 0, 0, 0);
    check("add_of", alu_of, 1);
    run(rtype(6'h25, 5'd7, 5'd4, 5'd0, 5'd0), 0, 0, 0);
    check("r4_unchanged", result, 0);

    run(itype(6'h0D, 5'd8, 5'd0, 16'h1234), 3, 1, 1);
    check("slow_fetch_ir", result, 32'h1234);

    do_reset();
    run(32'h0, 0, 0, 0);
    run(32'h0, 0, 0, 0);
    run(itype(6'h04, 5'd0, 5'd0, 16'hFFFF), 0, 0, 0);
`ifdef MC_CPU_BRANCH_EN
    check("beq_self", m_pc, 8'd8);
`else
    check("beq_illegal", illegal, 1);
`endif
    run(32'h0, 0, 0, 0);

    run(itype(6'h0D, 5'd5, 5'd0, 16'h00AA), 1, 0, 0);
    run_abort(itype(6'h08, 5'd5, 5'd0, 16'd9));
    run(rtype(6'h25, 5'd6, 5'd5, 5'd0, 5'd0), 0, 0, 1);
    check("abort_r5", result, 0);
    run(itype(6'h08, 5'd0, 5'd0, 16'd7), 0, 0, 0);
    run(rtype(6'h20, 5'd9, 5'd0, 5'd0, 5'd0), 0, 0, 0);
    check("r0_zero", result, 0);

    for (int n = 0; n < 160; n++)
      run(rand_instr(), $urandom_range(0, 2), 1'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
